// File: rtl/p_mul_multi.sv
// rtl/p_mul_multi.sv - packed-lane iterative multiplier, integer or carryless, lane width set by one-hot pw
module p_mul_multi #(
    parameter int XLEN = 32,
    parameter int PW_W = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            valid,
    output logic            ready,
    input  logic            mul_l,
    input  logic            mul_h,
    input  logic            clmul,
    input  logic [PW_W-1:0] pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [XLEN-1:0] crs2,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   crs1_q, crs1_d;
    logic [XLEN-1:0]   crs2_q, crs2_d;
    logic [PW_W-1:0]   pw_q, pw_d;
    logic              mul_h_q, mul_h_d;
    logic              clmul_q, clmul_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              pw_ok;
    logic [2*XLEN-1:0] acc_sel;
    logic [XLEN-1:0]   res_sel;
    logic              last_step;
    logic [2*XLEN-1:0] acc_cfg  [PW_W];
    logic [XLEN-1:0]   res_cfg  [PW_W];
    logic              last_cfg [PW_W];

    // Low-half select is the default, so mul_l alone never changes the outcome.
    logic unused_mul_l;
    assign unused_mul_l = mul_l;

    assign pw_ok = (pw != '0) && ((pw & (pw - PW_W'(1))) == '0);

    // One step of every lane for each possible lane width; lane k of width W keeps
    // its 2W-bit accumulator at acc_q[2Wk +: 2W], so lanes never share carries.
    for (genvar j = 0; j < PW_W; j++) begin : g_cfg
        localparam int W = XLEN >> j;
        localparam int N = 1 << j;

        logic [2*XLEN-1:0] acc_nx;
        logic [XLEN-1:0]   res_nx;
        logic [W-1:0]      hi, lo, addend;
        logic [W:0]        sum;
        logic [2*W-1:0]    lane;
        logic              bit_b;

        always_comb begin
            acc_nx = '0;
            res_nx = '0;
            hi     = '0;
            lo     = '0;
            addend = '0;
            sum    = '0;
            lane   = '0;
            bit_b  = 1'b0;
            for (int k = 0; k < N; k++) begin
                hi     = W'(acc_q >> (2*W*k + W));
                lo     = W'(acc_q >> (2*W*k));
                bit_b  = 1'((crs2_q >> (W*k)) >> count_q);
                addend = bit_b ? W'(crs1_q >> (W*k)) : '0;
                sum    = clmul_q ? {1'b0, hi ^ addend} : ({1'b0, hi} + {1'b0, addend});
                lane   = (2*W)'({sum, lo} >> 1);
                acc_nx = acc_nx | ((2*XLEN)'(lane) << (2*W*k));
                res_nx = res_nx | (XLEN'(mul_h_q ? lane[2*W-1:W] : lane[W-1:0]) << (W*k));
            end
        end

        assign acc_cfg[j]  = acc_nx;
        assign res_cfg[j]  = res_nx;
        assign last_cfg[j] = (count_q == CW'(W - 1));
    end

    always_comb begin
        acc_sel   = '0;
        res_sel   = '0;
        last_step = 1'b0;
        for (int j = 0; j < PW_W; j++) begin
            if (pw_q[j]) begin
                acc_sel   = acc_cfg[j];
                res_sel   = res_cfg[j];
                last_step = last_cfg[j];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid) state_d = pw_ok ? BUSY : DONE;
            BUSY:    if (!valid) state_d = IDLE;
                     else if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == DONE);
    end

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        crs1_d   = crs1_q;
        crs2_d   = crs2_q;
        pw_d     = pw_q;
        mul_h_d  = mul_h_q;
        clmul_d  = clmul_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (pw_ok) begin
                        crs1_d  = crs1;
                        crs2_d  = crs2;
                        pw_d    = pw;
                        mul_h_d = mul_h;
                        clmul_d = clmul;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        result_d = '0;
                    end
                end
            end
            BUSY: begin
                if (!valid) begin
                    acc_d   = '0;
                    count_d = '0;
                end else begin
                    acc_d   = acc_sel;
                    count_d = count_q + CW'(1);
                    if (last_step) begin
                        result_d = res_sel;
                        count_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q    <= '0;
            count_q  <= '0;
            crs1_q   <= '0;
            crs2_q   <= '0;
            pw_q     <= '0;
            mul_h_q  <= 1'b0;
            clmul_q  <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            crs1_q   <= crs1_d;
            crs2_q   <= crs2_d;
            pw_q     <= pw_d;
            mul_h_q  <= mul_h_d;
            clmul_q  <= clmul_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: doc/p_mul_multi.md
P_MUL_MULTI -- requirements
Module: p_mul_multi

Interface
REQ-001 Parameter XLEN, default 32, legal values 32 or 64: datapath width.
REQ-002 Parameter PW_W, default log2(XLEN): width of the one-hot pack-width select.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 valid  input  1  request; held high until ready, or dropped to abort.
REQ-006 ready  output  1  one-cycle completion pulse; result is valid in this cycle.
REQ-007 mul_l  input  1  return the low half of each lane product.
REQ-008 mul_h  input  1  return the high half of each lane product.
REQ-009 clmul  input  1  1 = carryless (XOR) accumulation; 0 = integer unsigned multiply.
REQ-010 pw  input  PW_W  one-hot pack width; pw[j] selects lane width W = XLEN>>j; smallest lane is 2 bits.
REQ-011 crs1  input  XLEN  multiplicand lanes.
REQ-012 crs2  input  XLEN  multiplier lanes.
REQ-013 result  output  XLEN  registered packed result; held until the next completion.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE with valid=1 and pw one-hot, the block SHALL latch crs1, crs2, pw, mul_h and clmul, clear the 2*XLEN accumulator and the counter, and go to BUSY.
REQ-016 Operands SHALL NOT be sampled after the IDLE->BUSY edge; crs1, crs2, pw and op inputs may change during BUSY.
REQ-017 Each BUSY cycle SHALL perform step i = count independently for every lane.
REQ-018 For each lane at step i, the upper W bits of the lane accumulator SHALL be combined with (crs2_lane[i] ? crs1_lane : 0).
REQ-019 The combine SHALL be a W-bit add with carry-out when clmul=0, and a bitwise XOR with zero carry when clmul=1.
REQ-020 After the combine, the {carry, sum, lower half} of each lane SHALL be shifted right by one bit.
REQ-021 No carry SHALL propagate across lane boundaries.
REQ-022 When count = W-1, the final step SHALL execute, the result register SHALL load, and the state SHALL go to DONE.
REQ-023 The loaded result SHALL be, per lane, product bits [W-1:0] if mul_h=0, else bits [2W-1:W].
REQ-024 ready SHALL be 1 only in DONE.
REQ-025 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-026 If valid is still high in that IDLE cycle, a new operation SHALL start.
REQ-027 Latency: with valid first high in cycle 0 from IDLE, ready SHALL be high in cycle W+1; back-to-back throughput is one result per W+2 cycles.
REQ-028 If valid=0 in BUSY, the block SHALL abort: go to IDLE next edge, clear the accumulator and counter, leave ready low, and leave result unchanged.
REQ-029 If valid=1 in IDLE with pw zero or not one-hot, the block SHALL go directly to DONE, load result with 0, and pulse ready in cycle 1.
REQ-030 mul_l and mul_h both high SHALL behave as mul_h=1.
REQ-031 Neither mul_l nor mul_h high SHALL behave as mul_l=1.
REQ-032 Carryless high half SHALL have bit 2W-1 of each lane equal to 0.
REQ-033 The counter SHALL be log2(XLEN)+1 bits wide and SHALL never exceed W-1 in BUSY.

Reset
REQ-034 resetn=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, accumulator 0, latched operands 0, ready 0 and result 0.
REQ-035 Reset asserted during BUSY or DONE SHALL discard the operation; no ready pulse SHALL follow release.
REQ-036 After resetn rises, the first sampled valid in IDLE SHALL start an operation normally.

Verification
REQ-037 XLEN=32, pw=5'b00001, mul_l, crs1=crs2=0x00010000 -> ready in cycle 33, result=0x00000000; repeat with mul_h -> result=0x00000001.
REQ-038 pw=5'b00100 (8-bit), crs1=0xFF100302, crs2=0xFF100507 -> mul_l result 0x01000F0E and mul_h result 0xFE010000, ready in cycle 9.
REQ-039 pw=5'b10000 (2-bit), crs1=crs2=0xFFFFFFFF -> mul_l 0x55555555, mul_h 0xAAAAAAAA; with clmul=1 -> mul_l 0x55555555, mul_h 0x55555555; ready in cycle 3.
REQ-040 pw=5'b00001, clmul=1, crs1=crs2=0x00000003, mul_l -> result 0x00000005; change crs1/crs2 from cycle 1 onward -> result unchanged.
REQ-041 Abort/reset: start 32-bit op, drop valid in cycle 10 -> no ready, result holds the previous value; restart, pulse resetn low in cycle 5 -> ready=0 and result=0 immediately, then a fresh op completes in cycle 33.
REQ-042 pw=5'b00011, valid high -> ready in cycle 1, result 0; hold valid for 2W+4 cycles with legal pw -> exactly two ready pulses, W+2 cycles apart.
